// File: rtl/scene_commit_ctrl_pkg.sv
// Shared definitions for the scene commit controller.
// Holds the object-table geometry, slot names, record layout and the
// controller state encoding.
package scene_commit_ctrl_pkg;

  localparam int NUM_OBJ = 9;
  localparam int COORD_W = 11;
  localparam int REC_W   = 3 * COORD_W;
  localparam int IDX_W   = 4;

  // Field offsets inside one packed record {velx, posy, posx}.
  localparam int X_LSB  = 0;
  localparam int Y_LSB  = COORD_W;
  localparam int VX_LSB = 2 * COORD_W;

  // Slot assignment: five balls, then the four paddles.
  typedef enum logic [IDX_W-1:0] {
    BALL0 = 4'd0,
    BALL1 = 4'd1,
    BALL2 = 4'd2,
    BALL3 = 4'd3,
    BALL4 = 4'd4,
    PAD10 = 4'd5,
    PAD11 = 4'd6,
    PAD20 = 4'd7,
    PAD21 = 4'd8
  } obj_slot_e;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    WAIT_VB = 2'd1,
    COPY    = 2'd2
  } state_e;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] vx
  );
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[X_LSB  +: COORD_W] = x;
    rec[Y_LSB  +: COORD_W] = y;
    rec[VX_LSB +: COORD_W] = vx;
    return rec;
  endfunction

endpackage

// File: rtl/scene_commit_ctrl_obj_bank.sv
// obj_bank: N x W register array with one write port and a flat read bus.
// Ports:
//   pclk, reset   clock, async active-high reset (all records -> RST_REC)
//   we_i          write enable
//   idx_i         record index; indices >= N are silently discarded
//   wdata_i       record data
//   rd_bus_o      all records, record i at [i*W +: W]
module obj_bank
  import scene_commit_ctrl_pkg::*;
#(
  parameter int           N       = NUM_OBJ,
  parameter int           W       = REC_W,
  parameter logic [W-1:0] RST_REC = '0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [W-1:0]     wdata_i,
  output logic [N*W-1:0]   rd_bus_o
);

  logic [W-1:0] rec_q [N];

  // NOTE: every record is reset (not left as uninitialised RAM) because the
  // renderer reads all of them continuously and must see off-screen values.
  // NOTE: sequential state uses non-blocking assignments so every record
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) rec_q[i] <= RST_REC;
    end else if (we_i && (idx_i < IDX_W'(N))) begin
      rec_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    rd_bus_o = '0;
    for (int i = 0; i < N; i++) rd_bus_o[i*W +: W] = rec_q[i];
  end

endmodule

// File: rtl/scene_commit_ctrl.sv
// scene_commit_ctrl: double-buffers object records between game logic and
// the VGA renderer. Game logic fills the shadow bank, signals frame_done,
// and the shadow bank is copied into the display bank one record per cycle
// starting at the next vertical-blank pulse. frame_tick paces game logic.
// Ports:
//   pclk, reset      pixel clock, async active-high reset
//   vblank_start     one-cycle pulse at start of vertical blank
//   wr_valid/ready   record write handshake (wr_idx, wr_posx/posy/velx)
//   frame_done       shadow bank complete for this frame
//   disp_bus         display bank, record i at [i*33 +: 33] = {velx,posy,posx}
//   frame_tick       one-cycle pulse after a commit finishes
//   busy             high while waiting for vblank or copying
//   missed_frames    saturating count of vblanks with no pending commit
//   bad_idx          sticky: out-of-range write index was accepted
module scene_commit_ctrl
  import scene_commit_ctrl_pkg::*;
#(
  parameter int RESET_X = -64,
  parameter int RESET_Y = -64
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       vblank_start,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [COORD_W-1:0]         wr_posx,
  input  logic [COORD_W-1:0]         wr_posy,
  input  logic [COORD_W-1:0]         wr_velx,
  input  logic                       frame_done,
  output logic [NUM_OBJ*REC_W-1:0]   disp_bus,
  output logic                       frame_tick,
  output logic                       busy,
  output logic [7:0]                 missed_frames,
  output logic                       bad_idx
);

  localparam logic [REC_W-1:0] RST_REC =
    pack_rec(COORD_W'(RESET_X), COORD_W'(RESET_Y), '0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   copy_cnt_q, copy_cnt_d;
  logic [7:0]         missed_q, missed_d;
  logic               bad_q, bad_d;
  logic               tick_q, tick_d;
  logic               shadow_we, disp_we;
  logic [NUM_OBJ*REC_W-1:0] shadow_bus;
  logic [REC_W-1:0]   copy_rec;

  assign copy_rec = shadow_bus[copy_cnt_q*REC_W +: REC_W];

  obj_bank #(.N(NUM_OBJ), .W(REC_W), .RST_REC(RST_REC)) u_shadow (
    .pclk     (pclk),
    .reset    (reset),
    .we_i     (shadow_we),
    .idx_i    (wr_idx),
    .wdata_i  (pack_rec(wr_posx, wr_posy, wr_velx)),
    .rd_bus_o (shadow_bus)
  );

  obj_bank #(.N(NUM_OBJ), .W(REC_W), .RST_REC(RST_REC)) u_display (
    .pclk     (pclk),
    .reset    (reset),
    .we_i     (disp_we),
    .idx_i    (copy_cnt_q),
    .wdata_i  (copy_rec),
    .rd_bus_o (disp_bus)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCEPT;
      copy_cnt_q <= '0;
      missed_q   <= '0;
      bad_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      copy_cnt_q <= copy_cnt_d;
      missed_q   <= missed_d;
      bad_q      <= bad_d;
      tick_q     <= tick_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    copy_cnt_d = copy_cnt_q;
    missed_d   = missed_q;
    bad_d      = bad_q;
    tick_d     = 1'b0;
    shadow_we  = 1'b0;
    disp_we    = 1'b0;

    case (state_q)
      ACCEPT: begin
        // The shadow write shares the frame_done edge, so it is committed.
        if (wr_valid) begin
          shadow_we = 1'b1;
          if (wr_idx >= IDX_W'(NUM_OBJ)) bad_d = 1'b1;
        end
        if (frame_done && vblank_start) begin
          state_d    = COPY;
          copy_cnt_d = '0;
        end else if (frame_done) begin
          state_d = WAIT_VB;
        end else if (vblank_start && (missed_q != 8'hFF)) begin
          missed_d = missed_q + 8'd1;
        end
      end
      WAIT_VB: begin
        if (vblank_start) begin
          state_d    = COPY;
          copy_cnt_d = '0;
        end
      end
      COPY: begin
        disp_we = 1'b1;
        if (copy_cnt_q == PAD21) begin
          state_d = ACCEPT;
          tick_d  = 1'b1;
        end else begin
          copy_cnt_d = copy_cnt_q + 1'b1;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  assign wr_ready      = (state_q == ACCEPT);
  assign busy          = (state_q != ACCEPT);
  assign frame_tick    = tick_q;
  assign missed_frames = missed_q;
  assign bad_idx       = bad_q;

endmodule

// File: tb/tb_scene_commit_ctrl.sv
// Directed testbench for scene_commit_ctrl.
module tb_scene_commit_ctrl;

  localparam int N   = 9;
  localparam int CW  = 11;
  localparam int RW  = 33;
  localparam int BW  = N * RW;

  logic           pclk = 1'b0;
  logic           reset = 1'b1;
  logic           vblank_start = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [3:0]     wr_idx = '0;
  logic [CW-1:0]  wr_posx = '0;
  logic [CW-1:0]  wr_posy = '0;
  logic [CW-1:0]  wr_velx = '0;
  logic           frame_done = 1'b0;
  logic [BW-1:0]  disp_bus;
  logic           frame_tick;
  logic           busy;
  logic [7:0]     missed_frames;
  logic           bad_idx;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;

  logic [RW-1:0]  exp_rec [N];
  logic [BW-1:0]  exp_bus;

  scene_commit_ctrl dut (
    .pclk          (pclk),
    .reset         (reset),
    .vblank_start  (vblank_start),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_idx        (wr_idx),
    .wr_posx       (wr_posx),
    .wr_posy       (wr_posy),
    .wr_velx       (wr_velx),
    .frame_done    (frame_done),
    .disp_bus      (disp_bus),
    .frame_tick    (frame_tick),
    .busy          (busy),
    .missed_frames (missed_frames),
    .bad_idx       (bad_idx)
  );

  always #20 pclk = ~pclk;

  always @(posedge pclk) if (frame_tick) tick_count++;

  function automatic logic [RW-1:0] mk(input int x, input int y, input int vx);
    return {CW'(vx), CW'(y), CW'(x)};
  endfunction

  function automatic logic [BW-1:0] flat();
    logic [BW-1:0] b;
    for (int i = 0; i < N; i++) b[i*RW +: RW] = exp_rec[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) exp_rec[i] = mk(-64, -64, 0);
  endtask

  initial begin
    int t0;
    int ready_hi;
    reset_model();

    // Reset state
    step(3);
    reset = 1'b0;
    step(1);
    check("rst_wr_ready", BW'(wr_ready), BW'(1));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_tick", BW'(frame_tick), BW'(0));
    check("rst_missed", BW'(missed_frames), BW'(0));
    check("rst_bad", BW'(bad_idx), BW'(0));
    check("rst_disp", disp_bus, flat());

    // Two idle frames
    for (int f = 0; f < 2; f++) begin
      step(100);
      vblank_start = 1'b1; step(1); vblank_start = 1'b0;
    end
    step(20);
    check("idle_missed", BW'(missed_frames), BW'(2));
    check("idle_disp", disp_bus, flat());
    check("idle_no_tick", BW'(tick_count), BW'(0));

    // Write ball0, frame_done, vblank 1000 cycles later
    wr_valid = 1'b1; wr_idx = 4'd0;
    wr_posx = CW'(100); wr_posy = CW'(200); wr_velx = CW'(-3);
    step(1);
    wr_valid = 1'b0;
    frame_done = 1'b1; step(1); frame_done = 1'b0;
    check("wait_ready", BW'(wr_ready), BW'(0));
    check("wait_busy", BW'(busy), BW'(1));
    step(1000);
    check("wait_ready_late", BW'(wr_ready), BW'(0));
    check("wait_disp", disp_bus, flat());
    t0 = tick_count;
    vblank_start = 1'b1; step(1); vblank_start = 1'b0;
    check("copy0_disp_unchanged", disp_bus, flat());
    step(1);
    exp_rec[0] = mk(100, 200, -3);
    check("copy1_rec0", disp_bus, flat());
    ready_hi = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (wr_ready) ready_hi++;
    end
    check("copy_ready_low", BW'(ready_hi), BW'(0));
    check("copy_tick_early", BW'(frame_tick), BW'(0));
    step(1);
    check("copy_tick", BW'(frame_tick), BW'(1));
    check("copy_done_busy", BW'(busy), BW'(0));
    check("copy_disp", disp_bus, flat());
    step(1);
    check("tick_once", BW'(tick_count - t0), BW'(1));
    check("missed_kept", BW'(missed_frames), BW'(2));

    // frame_done coincident with vblank_start
    frame_done = 1'b1; vblank_start = 1'b1; step(1);
    frame_done = 1'b0; vblank_start = 1'b0;
    check("coinc_busy", BW'(busy), BW'(1));
    step(8);
    check("coinc_tick_9", BW'(frame_tick), BW'(0));
    step(1);
    check("coinc_tick_10", BW'(frame_tick), BW'(1));
    check("coinc_missed", BW'(missed_frames), BW'(2));
    step(5);

    // Write paddle21 together with frame_done
    wr_valid = 1'b1; wr_idx = 4'd8;
    wr_posx = CW'(300); wr_posy = CW'(-5); wr_velx = CW'(7);
    frame_done = 1'b1; step(1);
    wr_valid = 1'b0; frame_done = 1'b0;
    step(50);
    vblank_start = 1'b1; step(1); vblank_start = 1'b0;
    step(10);
    exp_rec[8] = mk(300, -5, 7);
    check("pad21_disp", disp_bus, flat());

    // Out-of-range write index
    wr_valid = 1'b1; wr_idx = 4'd12;
    wr_posx = CW'(1); wr_posy = CW'(2); wr_velx = CW'(3);
    #1;
    check("bad_ready", BW'(wr_ready), BW'(1));
    step(1);
    wr_valid = 1'b0;
    check("bad_flag", BW'(bad_idx), BW'(1));
    frame_done = 1'b1; vblank_start = 1'b1; step(1);
    frame_done = 1'b0; vblank_start = 1'b0;
    step(12);
    check("bad_no_alter", disp_bus, flat());
    check("bad_sticky", BW'(bad_idx), BW'(1));

    // Reset in the fourth COPY cycle
    frame_done = 1'b1; vblank_start = 1'b1; step(1);
    frame_done = 1'b0; vblank_start = 1'b0;
    step(3);
    reset = 1'b1; #2;
    reset_model();
    check("midrst_disp", disp_bus, flat());
    check("midrst_ready", BW'(wr_ready), BW'(1));
    check("midrst_busy", BW'(busy), BW'(0));
    check("midrst_bad", BW'(bad_idx), BW'(0));
    step(2);
    reset = 1'b0;
    step(1);
    // Shadow was also reset: a commit now leaves display at reset values
    frame_done = 1'b1; vblank_start = 1'b1; step(1);
    frame_done = 1'b0; vblank_start = 1'b0;
    step(12);
    check("midrst_shadow", disp_bus, flat());

    // Missed-frame saturation
    for (int f = 0; f < 254; f++) begin
      vblank_start = 1'b1; step(1); vblank_start = 1'b0; step(1);
    end
    check("missed_254", BW'(missed_frames), BW'(254));
    for (int f = 0; f < 46; f++) begin
      vblank_start = 1'b1; step(1); vblank_start = 1'b0; step(1);
    end
    check("missed_sat", BW'(missed_frames), BW'(255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
